// File: rtl/speed_loop_controller_if.sv
// Control and status bundle linking the speed loop controller to its register block,
// the RPM detector and the motor bridge.
interface speed_loop_controller_if;
  logic        enable;
  logic [31:0] setpoint;
  logic [15:0] kp;
  logic [15:0] ki;
  logic [31:0] rpm_in;
  logic        rpm_valid;
  logic [15:0] duty_cmd;
  logic        pwm_out;
  logic        stall_fault;
  logic        sample_drop;

  modport master (output enable, setpoint, kp, ki, rpm_in, rpm_valid,
                  input  duty_cmd, pwm_out, stall_fault, sample_drop);
  modport slave  (input  enable, setpoint, kp, ki, rpm_in, rpm_valid,
                  output duty_cmd, pwm_out, stall_fault, sample_drop);
endinterface

// File: rtl/speed_loop_controller.sv
// PI speed loop: one RPM sample per gate window -> saturated PI law -> glitch-free PWM drive.
//  state    | meaning
//  ST_IDLE  | loop off, integrator/fault cleared, duty 0
//  ST_WAIT  | waiting for an rpm_valid strobe
//  ST_ERR   | error computation + stall check
//  ST_MUL   | gain products
//  ST_SUM   | integrator update, duty command update
//  ST_FAULT | stall latched, duty held 0 until enable drops
module speed_loop_controller #(
  parameter int PWM_PERIOD    = 1000,
  parameter int STALL_WINDOWS = 3
) (
  input logic                    clock,
  input logic                    reset,
  speed_loop_controller_if.slave ctrl
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ERR, ST_MUL, ST_SUM, ST_FAULT} state_t;

  localparam int CW  = $clog2(PWM_PERIOD);
  localparam int SCW = $clog2(STALL_WINDOWS + 1);
  localparam logic [CW-1:0]        CNT_LAST    = CW'(PWM_PERIOD - 1);
  localparam logic [SCW-1:0]       STALL_LIMIT = SCW'(STALL_WINDOWS);
  localparam logic signed [33:0]   INTEG_MAX   = 34'(PWM_PERIOD * 256);
  localparam logic signed [33:0]   INTEG_MIN   = -INTEG_MAX;
  localparam logic signed [34:0]   U_MAX       = 35'(PWM_PERIOD);
  localparam logic signed [32:0]   ERR_MAX     = 33'sd32767;
  localparam logic signed [32:0]   ERR_MIN     = -33'sd32768;

  state_t             state_q, state_d;
  logic [31:0]        rpm_q, rpm_d;
  logic signed [15:0] err_q, err_d;
  logic signed [32:0] p_q, p_d;
  logic signed [32:0] iinc_q, iinc_d;
  logic signed [32:0] integ_q, integ_d;
  logic [15:0]        duty_cmd_q, duty_cmd_d;
  logic               stall_fault_q, stall_fault_d;
  logic               sample_drop_q, sample_drop_d;
  logic [SCW-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [15:0]        duty_act_q, duty_act_d;
  logic               pwm_q, pwm_d;

  logic               force_zero;
  logic               pwm_wrap;
  logic signed [32:0] err_wide;
  logic signed [33:0] integ_sum;
  logic signed [32:0] integ_sat;
  logic signed [34:0] u_sum;
  logic signed [34:0] u_shift;
  logic [15:0]        duty_sat;

  // Wide arithmetic, kept apart from the FSM so each stage reads its operands from registers.
  always_comb begin
    err_wide  = $signed({1'b0, ctrl.setpoint}) - $signed({1'b0, rpm_q});
    integ_sum = $signed({integ_q[32], integ_q}) + $signed({iinc_q[32], iinc_q});
    if (integ_sum > INTEG_MAX) begin
      integ_sat = INTEG_MAX[32:0];
    end else if (integ_sum < INTEG_MIN) begin
      integ_sat = INTEG_MIN[32:0];
    end else begin
      integ_sat = integ_sum[32:0];
    end
    u_sum   = $signed({{2{p_q[32]}}, p_q}) + $signed({{2{integ_sat[32]}}, integ_sat});
    u_shift = u_sum >>> 8;
    if (u_shift < 35'sd0) begin
      duty_sat = '0;
    end else if (u_shift > U_MAX) begin
      duty_sat = 16'(PWM_PERIOD);
    end else begin
      duty_sat = u_shift[15:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    rpm_d         = rpm_q;
    err_d         = err_q;
    p_d           = p_q;
    iinc_d        = iinc_q;
    integ_d       = integ_q;
    duty_cmd_d    = duty_cmd_q;
    stall_fault_d = stall_fault_q;
    sample_drop_d = 1'b0;
    stall_cnt_d   = stall_cnt_q;
    force_zero    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        integ_d       = '0;
        duty_cmd_d    = '0;
        stall_fault_d = 1'b0;
        stall_cnt_d   = '0;
        force_zero    = 1'b1;
        if (ctrl.enable) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ctrl.rpm_valid) begin
          rpm_d   = ctrl.rpm_in;
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        sample_drop_d = ctrl.rpm_valid;
        if (err_wide > ERR_MAX) begin
          err_d = 16'sh7fff;
        end else if (err_wide < ERR_MIN) begin
          err_d = 16'sh8000;
        end else begin
          err_d = err_wide[15:0];
        end
        if ((ctrl.setpoint != '0) && (rpm_q == '0)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          stall_cnt_d = '0;
        end
        if (stall_cnt_d == STALL_LIMIT) begin
          stall_fault_d = 1'b1;
          duty_cmd_d    = '0;
          force_zero    = 1'b1;
          state_d       = ST_FAULT;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        sample_drop_d = ctrl.rpm_valid;
        p_d     = $signed({17'b0, ctrl.kp}) * $signed({{17{err_q[15]}}, err_q});
        iinc_d  = $signed({17'b0, ctrl.ki}) * $signed({{17{err_q[15]}}, err_q});
        state_d = ST_SUM;
      end
      ST_SUM: begin
        sample_drop_d = ctrl.rpm_valid;
        integ_d       = integ_sat;
        duty_cmd_d    = duty_sat;
        state_d       = ST_WAIT;
      end
      ST_FAULT: begin
        duty_cmd_d    = '0;
        stall_fault_d = 1'b1;
        force_zero    = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping enable aborts whatever is in flight and parks the bridge low on the next edge.
    if (!ctrl.enable && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      duty_cmd_d    = '0;
      stall_fault_d = 1'b0;
      integ_d       = '0;
      stall_cnt_d   = '0;
      force_zero    = 1'b1;
    end
  end

  // Duty changes only at the period boundary, except a forced zero which must cut drive at once.
  always_comb begin
    pwm_wrap  = (pwm_cnt_q == CNT_LAST);
    pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
    if (force_zero) begin
      duty_act_d = '0;
    end else if (pwm_wrap) begin
      duty_act_d = duty_cmd_q;
    end else begin
      duty_act_d = duty_act_q;
    end
    pwm_d = (16'(pwm_cnt_d) < duty_act_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rpm_q         <= '0;
      err_q         <= '0;
      p_q           <= '0;
      iinc_q        <= '0;
      integ_q       <= '0;
      duty_cmd_q    <= '0;
      stall_fault_q <= 1'b0;
      sample_drop_q <= 1'b0;
      stall_cnt_q   <= '0;
      pwm_cnt_q     <= '0;
      duty_act_q    <= '0;
      pwm_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rpm_q         <= rpm_d;
      err_q         <= err_d;
      p_q           <= p_d;
      iinc_q        <= iinc_d;
      integ_q       <= integ_d;
      duty_cmd_q    <= duty_cmd_d;
      stall_fault_q <= stall_fault_d;
      sample_drop_q <= sample_drop_d;
      stall_cnt_q   <= stall_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_act_q    <= duty_act_d;
      pwm_q         <= pwm_d;
    end
  end

  assign ctrl.duty_cmd    = duty_cmd_q;
  assign ctrl.pwm_out     = pwm_q;
  assign ctrl.stall_fault = stall_fault_q;
  assign ctrl.sample_drop = sample_drop_q;

endmodule

// File: tb/tb_speed_loop_controller.sv
// Directed bench for the speed loop controller: stimulus queues expected observations,
// a negedge monitor pops and compares them at their due cycle.
module tb_speed_loop_controller;

  localparam int K_DUTY   = 0;
  localparam int K_FAULT  = 1;
  localparam int K_DROP   = 2;
  localparam int K_PWM    = 3;
  localparam int K_PWMCNT = 4;

  typedef struct {
    int    due;
    int    kind;
    int    val;
    int    base;
    string name;
  } exp_t;

  logic  clock = 1'b0;
  logic  reset;
  int    cyc = 0;
  int    tests = 0;
  int    failed = 0;
  int    pwm_hi_total = 0;
  int    rst_cyc = 0;
  int    cur_duty = 0;
  bit    finish_req = 1'b0;
  exp_t  sb[$];

  speed_loop_controller_if bus ();

  speed_loop_controller dut (
    .clock (clock),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    int act;
    if (bus.pwm_out === 1'b1) pwm_hi_total++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_DUTY:  act = int'(bus.duty_cmd);
          K_FAULT: act = int'(bus.stall_fault);
          K_DROP:  act = int'(bus.sample_drop);
          K_PWM:   act = int'(bus.pwm_out);
          default: act = pwm_hi_total - sb[i].base;
        endcase
        tests++;
        if (act != sb[i].val) begin
          failed++;
          $display("FAIL %s: got %0d, expected %0d (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
    if (finish_req) begin
      foreach (sb[j]) begin
        tests++;
        failed++;
        $display("FAIL %s: never observed, expected %0d at cycle %0d", sb[j].name, sb[j].val, sb[j].due);
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int dly, input int kind, input int val, input string name);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    e.base = pwm_hi_total;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic strobe(input logic [31:0] r);
    bus.rpm_in    = r;
    bus.rpm_valid = 1'b1;
    tick();
    bus.rpm_valid = 1'b0;
  endtask

  // One sample through the pipeline: old duty still visible 3 cycles on, new one at 4.
  task automatic sample(input logic [31:0] r, input int exp_duty, input string name);
    push(3, K_DUTY, cur_duty, {name, "_hold"});
    push(4, K_DUTY, exp_duty, name);
    strobe(r);
    tick();
    tick();
    tick();
    cur_duty = exp_duty;
  endtask

  function automatic int phase();
    return (cyc - rst_cyc) % 1000;
  endfunction

  task automatic wait_phase(input int ph);
    for (int n = 0; n < 1000 && phase() != ph; n++) tick();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.setpoint  = '0;
    bus.kp        = '0;
    bus.ki        = '0;
    bus.rpm_in    = '0;
    bus.rpm_valid = 1'b0;

    // T1: reset held with enable high and strobes arriving
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.rpm_valid = (i % 2 == 0);
      bus.rpm_in    = 32'd77;
      push(0, K_DUTY,  0, "t1_duty");
      push(0, K_PWM,   0, "t1_pwm");
      push(0, K_FAULT, 0, "t1_fault");
      push(0, K_DROP,  0, "t1_drop");
    end
    bus.rpm_valid = 1'b0;
    reset         = 1'b1;
    rst_cyc       = cyc;
    ticks(2);

    // T2: P-only, 500-200 at gain 1.0
    bus.setpoint = 32'd500;
    bus.kp       = 16'h0100;
    sample(32'd200, 300, "t2_duty");
    ticks(1000);
    push(999, K_PWMCNT, 300, "t2_pwm_width");
    ticks(1000);

    // T6a: duty update mid-period only takes effect after the wrap
    wait_phase(10);
    push(390,  K_PWM, 0, "t6_old_width_kept");
    push(1390, K_PWM, 1, "t6_new_width_high");
    push(1640, K_PWM, 0, "t6_new_width_low");
    bus.setpoint = 32'd800;
    sample(32'd200, 600, "t6_mid_duty");
    wait_phase(0);
    push(999, K_PWMCNT, 600, "t6_next_period_width");
    ticks(1000);

    // T6b: negative error clamps to zero duty
    bus.setpoint = 32'd100;
    sample(32'd400, 0, "t6_neg_err");

    // Error saturation: 99999 clips to 32767, kp=1/256 -> 127
    bus.setpoint = 32'd100000;
    bus.kp       = 16'h0001;
    sample(32'd1, 127, "err_sat");

    // T3: integral windup and clamp
    bus.setpoint = 32'd5000;
    bus.kp       = 16'h0000;
    bus.ki       = 16'h0100;
    for (int i = 0; i < 20; i++) sample(32'(i % 2), 1000, "t3_clamp");
    ticks(1000);
    push(999, K_PWMCNT, 1000, "t3_full_high");
    ticks(1000);
    sample(32'd6000, 0, "t3_unwind");

    // T4: stall detection and recovery
    bus.ki       = 16'h0000;
    bus.kp       = 16'h0100;
    bus.setpoint = 32'd100;
    sample(32'd0, 100, "t4_stall1");
    sample(32'd0, 100, "t4_stall2");
    push(1, K_FAULT, 0, "t4_no_fault_yet");
    push(2, K_FAULT, 1, "t4_fault");
    push(2, K_DUTY,  0, "t4_fault_duty");
    push(3, K_PWM,   0, "t4_fault_pwm");
    strobe(32'd0);
    ticks(3);
    push(1, K_DROP,  0, "t4_fault_no_drop");
    push(3, K_FAULT, 1, "t4_fault_held");
    strobe(32'd0);
    ticks(3);
    push(999, K_PWMCNT, 0, "t4_pwm_low");
    ticks(1000);
    bus.enable = 1'b0;
    push(2, K_FAULT, 0, "t4_fault_cleared");
    ticks(3);
    bus.enable = 1'b1;
    ticks(2);
    cur_duty = 0;
    sample(32'd50, 50, "t4_resume");

    // T5: back-to-back strobes, second is dropped
    bus.setpoint = 32'd500;
    push(1, K_DROP, 0, "t5_drop_before");
    push(2, K_DROP, 1, "t5_drop_pulse");
    push(3, K_DROP, 0, "t5_drop_after");
    push(4, K_DUTY, 400, "t5_first_only");
    push(9, K_DUTY, 400, "t5_second_ignored");
    bus.rpm_in    = 32'd100;
    bus.rpm_valid = 1'b1;
    tick();
    bus.rpm_in    = 32'd450;
    tick();
    bus.rpm_valid = 1'b0;
    ticks(10);

    // Reset in the middle of a computation discards it
    strobe(32'd0);
    tick();
    reset = 1'b0;
    push(1, K_DUTY,  0, "rst_mid_duty");
    push(1, K_FAULT, 0, "rst_mid_fault");
    push(1, K_PWM,   0, "rst_mid_pwm");
    ticks(2);
    reset   = 1'b1;
    rst_cyc = cyc;
    ticks(2);
    cur_duty = 0;
    sample(32'd300, 200, "rst_resume");

    ticks(5);
    finish_req = 1'b1;
  end

endmodule
